unidade_controle_multiciclo: RTL and testbench
==============================================

# unidade_controle_multiciclo

Multi-cycle control unit for the RV64 datapath: register file, ULA, data memory, ULAPC/ProgramCounter and immediate generators. It replaces hand-sequenced per-instruction control with a synthesizable state machine. It fetches, decodes and steps each instruction through BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA, driving every write enable and mux select. Data-memory latency is parametrised. Illegal opcodes are trapped.

## Interface
- MEM_LAT, 1, cycles spent in MEMORIA per access (legal 1..15)
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction from MemoriaInstrucao, valid from the cycle after ir_load
- zero  in  1  ULA result == 0 (used only with branches)
- ir_load  out  1  capture instruction / start fetch
- pc_load  out  1  ProgramCounter update enable
- pc_src  out  2  0=PC+4, 1=PC+imm_J, 2=(rs1+imm_I)&~1, 3=PC+imm_B
- WeR  out  1  register-file write enable
- WeM  out  1  data-memory write enable
- wb_sel  out  2  0=ULA, 1=memory, 2=PC+4 (link), 3=PC+imm_U
- imediato  out  1  ULA operand B = immediate
- subtraindo  out  1  ULA subtracts
- estado  out  3  current state (debug)
- illegal  out  1  sticky illegal-instruction flag

## Operation
- States: BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, TRAVA=7.
- BUSCA: ir_load=1. Next state is DECODIFICA.
- DECODIFICA: classifies opcode/funct3/funct7 and registers the class internally. Later states use only the registered class.
- Classes, their paths and the actions asserted in each state:
  - R (0110011, f3=000, f7=0000000 ADD / 0100000 SUB): BUSCA→DEC→EXEC→ESCRITA.
    - EXEC: subtraindo=f7[5].
    - ESCRITA: WeR=1, wb_sel=0, pc_load=1, pc_src=0.
  - ADDI (0010011, f3=000): same path as R, with imediato=1 and subtraindo=0.
  - LD (0000011, f3=011): BUSCA→DEC→EXEC→MEMORIA→ESCRITA.
    - EXEC: imediato=1.
    - ESCRITA: wb_sel=1, WeR=1, pc_load=1, pc_src=0.
  - SD (0100011, f3=011): BUSCA→DEC→EXEC→MEMORIA→BUSCA.
    - WeM=1 only in the last MEMORIA cycle, together with pc_load=1 and pc_src=0.
  - AUIPC (0010111): BUSCA→DEC→ESCRITA.
    - ESCRITA: WeR=1, wb_sel=3, pc_load=1, pc_src=0.
  - JAL (1101111): BUSCA→DEC→EXEC→BUSCA.
    - EXEC: WeR=1, wb_sel=2, pc_load=1, pc_src=1.
  - JALR (1100111, f3=000): same path as JAL, with pc_src=2.
  - Anything else: DEC→TRAVA.
- TRAVA: illegal=1, all enables 0. The unit stays in TRAVA until rst.
- MEMORIA uses an internal down-counter loaded with MEM_LAT-1 on entry. The unit leaves MEMORIA when the counter is 0, so it spends exactly MEM_LAT cycles there.
- Unused outputs are 0 in every state. The outputs are a Moore-style decode of estado plus the registered class. zero is the only Mealy input (branch pc_src).

## Timing
- Reset: when rst is sampled high, estado=BUSCA and the class register and counter clear. While rst=1, every output is 0 (ir_load is gated by rst) and illegal=0.
- Reset mid-instruction aborts it. No WeR/WeM/pc_load is asserted in the cycle rst is high.
- Instruction latency with MEM_LAT=1:
  - R/ADDI: 4 cycles
  - LD: 5 cycles
  - SD: 4 cycles
  - AUIPC, JAL, JALR, branch: 3 cycles
- LD and SD take MEM_LAT-1 additional cycles.
- pc_load is asserted exactly once per retired instruction, in its last cycle. The next cycle is always BUSCA.
- WeR and WeM are never both 1 in the same cycle.
- The SD write never coincides with a register write.
- Writes to x0 are the register file's responsibility; the unit asserts WeR regardless of rd.

## Configuration
- RV_BRANCH_EN defined: BEQ/BNE (1100011, f3=000/001) are legal.
  - Path: BUSCA→DEC→EXEC→BUSCA.
  - EXEC: subtraindo=1, pc_load=1.
  - pc_src=3 when taken (BEQ: zero=1; BNE: zero=0), otherwise 0.
- RV_BRANCH_EN undefined: opcode 1100011 decodes as illegal and goes to TRAVA.

## Test plan
- rst=1 for 2 cycles, then 0 → estado=0 and all outputs 0 during reset. ir_load=1 in the first cycle after release.
- ADD x3,x1,x2 (0x002081B3), then SUB (0x402081B3) → each takes 4 cycles. WeR=1/wb_sel=0/pc_load=1 in cycle 4. subtraindo=0 for ADD, 1 for SUB.
- LD with MEM_LAT=3 (0x0000B183) → 7 cycles, WeR in cycle 7 with wb_sel=1. SD (0x0030B023) → WeM=1 only in cycle 6, WeR never asserted.
- AUIPC x4,1 (0x00001217) → 3 cycles, ESCRITA wb_sel=3. JALR x5,0(x4) (0x000202E7) → EXEC WeR=1, wb_sel=2, pc_src=2.
- With RV_BRANCH_EN: BEQ (0x00208463) with zero=1 → pc_src=3; with zero=0 → pc_src=0. Without RV_BRANCH_EN, the same word → TRAVA, illegal=1.
- Instruction word 0xFFFFFFFF → TRAVA in cycle 3, illegal stays 1 for 10 cycles. rst then clears it and estado returns to 0.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit for the RV64 datapath: BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA sequencing.
// Optional feature: define RV_BRANCH_EN to accept BEQ/BNE; otherwise opcode 1100011 traps.
module unidade_controle_multiciclo #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic        WeR,
  output logic        WeM,
  output logic [1:0]  wb_sel,
  output logic        imediato,
  output logic        subtraindo,
  output logic [2:0]  estado,
  output logic        illegal
);

  typedef enum logic [2:0] {
    BUSCA = 3'd0, DECODIFICA = 3'd1, EXECUTA = 3'd2,
    MEMORIA = 3'd3, ESCRITA = 3'd4, TRAVA = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ADD, C_SUB, C_ADDI, C_LD, C_SD, C_AUIPC,
    C_JAL, C_JALR, C_BEQ, C_BNE, C_ILL
  } class_t;

  state_t     state, state_nxt;
  class_t     cls, dec;
  logic [3:0] cnt;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Register indices and immediates belong to the datapath, not to this unit.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = C_ILL;
    case (opcode)
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000)      dec = C_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) dec = C_SUB;
      end
      7'b0010011: if (f3 == 3'b000) dec = C_ADDI;
      7'b0000011: if (f3 == 3'b011) dec = C_LD;
      7'b0100011: if (f3 == 3'b011) dec = C_SD;
      7'b0010111: dec = C_AUIPC;
      7'b1101111: dec = C_JAL;
      7'b1100111: if (f3 == 3'b000) dec = C_JALR;
`ifdef RV_BRANCH_EN
      7'b1100011: begin
        if (f3 == 3'b000)      dec = C_BEQ;
        else if (f3 == 3'b001) dec = C_BNE;
      end
`endif
      default: dec = C_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUSCA;
      cls   <= C_NONE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == DECODIFICA) cls <= dec;
      // Counter is reloaded in EXECUTA so it holds MEM_LAT-1 on entry to MEMORIA.
      if (state == EXECUTA)                     cnt <= 4'(MEM_LAT - 1);
      else if (state == MEMORIA && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_src     = 2'd0;
    WeR        = 1'b0;
    WeM        = 1'b0;
    wb_sel     = 2'd0;
    imediato   = 1'b0;
    subtraindo = 1'b0;
    illegal    = 1'b0;
    case (state)
      BUSCA: begin
        ir_load   = 1'b1;
        state_nxt = DECODIFICA;
      end
      DECODIFICA: begin
        case (dec)
          C_AUIPC: state_nxt = ESCRITA;
          C_ILL:   state_nxt = TRAVA;
          default: state_nxt = EXECUTA;
        endcase
      end
      EXECUTA: begin
        state_nxt = BUSCA;
        case (cls)
          C_ADD:  state_nxt = ESCRITA;
          C_SUB:  begin subtraindo = 1'b1; state_nxt = ESCRITA; end
          C_ADDI: begin imediato = 1'b1;   state_nxt = ESCRITA; end
          C_LD:   begin imediato = 1'b1;   state_nxt = MEMORIA; end
          C_SD:   state_nxt = MEMORIA;
          C_JAL:  begin WeR = 1'b1; wb_sel = 2'd2; pc_load = 1'b1; pc_src = 2'd1; end
          C_JALR: begin WeR = 1'b1; wb_sel = 2'd2; pc_load = 1'b1; pc_src = 2'd2; end
          C_BEQ:  begin subtraindo = 1'b1; pc_load = 1'b1; pc_src = zero ? 2'd3 : 2'd0; end
          C_BNE:  begin subtraindo = 1'b1; pc_load = 1'b1; pc_src = zero ? 2'd0 : 2'd3; end
          default: ;
        endcase
      end
      MEMORIA: begin
        if (cnt == 4'd0) begin
          if (cls == C_SD) begin
            WeM       = 1'b1;
            pc_load   = 1'b1;
            state_nxt = BUSCA;
          end else begin
            state_nxt = ESCRITA;
          end
        end
      end
      ESCRITA: begin
        WeR       = 1'b1;
        pc_load   = 1'b1;
        state_nxt = BUSCA;
        case (cls)
          C_LD:    wb_sel = 2'd1;
          C_AUIPC: wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
      end
      TRAVA: illegal = 1'b1;
      default: state_nxt = BUSCA;
    endcase
    // Reset masks every output so an aborted instruction commits nothing.
    if (rst) begin
      ir_load    = 1'b0;
      pc_load    = 1'b0;
      pc_src     = 2'd0;
      WeR        = 1'b0;
      WeM        = 1'b0;
      wb_sel     = 2'd0;
      imediato   = 1'b0;
      subtraindo = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for unidade_controle_multiciclo with MEM_LAT=3; honours RV_BRANCH_EN.
module tb_unidade_controle_multiciclo;

  logic        clk, rst, zero;
  logic [31:0] instr;
  logic        ir_load, pc_load, WeR, WeM, imediato, subtraindo, illegal;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  estado;

  int n_checks = 0;
  int n_fail   = 0;

  unidade_controle_multiciclo #(.MEM_LAT(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
    .WeR(WeR), .WeM(WeM), .wb_sel(wb_sel), .imediato(imediato),
    .subtraindo(subtraindo), .estado(estado), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed view: {estado, ir_load, pc_load, pc_src, WeR, WeM, wb_sel, imediato, subtraindo, illegal}
  function automatic logic [13:0] pack(input logic [2:0] st, input logic ir, input logic pcl,
                                       input logic [1:0] pcs, input logic wer, input logic wem,
                                       input logic [1:0] wb, input logic imm, input logic sub,
                                       input logic ill);
    return {st, ir, pcl, pcs, wer, wem, wb, imm, sub, ill};
  endfunction

  function automatic logic [13:0] observed();
    return pack(estado, ir_load, pc_load, pc_src, WeR, WeM, wb_sel, imediato, subtraindo, illegal);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic ir, input logic pcl,
                     input logic [1:0] pcs, input logic wer, input logic wem,
                     input logic [1:0] wb, input logic imm, input logic sub, input logic ill);
    check(tag, 32'(observed()), 32'(pack(st, ir, pcl, pcs, wer, wem, wb, imm, sub, ill)));
    step();
  endtask

  task automatic fetch_dec(input string tag, input logic [31:0] word);
    instr = word;
    cyc({tag, "_busca"}, 3'd0, 1, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    cyc({tag, "_dec"},   3'd1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_outs_zero"}, 32'(observed() & 14'h07FF), 32'd0);
    step();
    check({tag, "_rst_estado"}, 32'(observed()), 32'(pack(3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0)));
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; instr = 32'd0;
    step();
    cyc("reset_c1", 3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    check("reset_c2", 32'(observed()), 32'(pack(3'd0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0)));
    rst = 1'b0;
    #1;

    fetch_dec("add", 32'h002081B3);
    cyc("add_exec", 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    cyc("add_wb",   3'd4, 0, 1, 2'd0, 1, 0, 2'd0, 0, 0, 0);

    fetch_dec("sub", 32'h402081B3);
    cyc("sub_exec", 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1, 0);
    cyc("sub_wb",   3'd4, 0, 1, 2'd0, 1, 0, 2'd0, 0, 0, 0);

    fetch_dec("addi", 32'h00108093);
    cyc("addi_exec", 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0);
    cyc("addi_wb",   3'd4, 0, 1, 2'd0, 1, 0, 2'd0, 0, 0, 0);

    fetch_dec("ld", 32'h0000B183);
    cyc("ld_exec", 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("ld_mem", 3'd3, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    cyc("ld_wb", 3'd4, 0, 1, 2'd0, 1, 0, 2'd1, 0, 0, 0);

    fetch_dec("sd", 32'h0030B023);
    cyc("sd_exec", 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    cyc("sd_mem1", 3'd3, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    cyc("sd_mem2", 3'd3, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    cyc("sd_mem3", 3'd3, 0, 1, 2'd0, 0, 1, 2'd0, 0, 0, 0);

    fetch_dec("auipc", 32'h00001217);
    cyc("auipc_wb", 3'd4, 0, 1, 2'd0, 1, 0, 2'd3, 0, 0, 0);

    fetch_dec("jalr", 32'h000202E7);
    cyc("jalr_exec", 3'd2, 0, 1, 2'd2, 1, 0, 2'd2, 0, 0, 0);

    fetch_dec("jal", 32'h0080006F);
    cyc("jal_exec", 3'd2, 0, 1, 2'd1, 1, 0, 2'd2, 0, 0, 0);

`ifdef RV_BRANCH_EN
    zero = 1'b1;
    fetch_dec("beq_t", 32'h00208463);
    cyc("beq_taken", 3'd2, 0, 1, 2'd3, 0, 0, 2'd0, 0, 1, 0);
    zero = 1'b0;
    fetch_dec("beq_nt", 32'h00208463);
    cyc("beq_not_taken", 3'd2, 0, 1, 2'd0, 0, 0, 2'd0, 0, 1, 0);
    zero = 1'b0;
    fetch_dec("bne_t", 32'h00209463);
    cyc("bne_taken", 3'd2, 0, 1, 2'd3, 0, 0, 2'd0, 0, 1, 0);
`else
    fetch_dec("beq_off", 32'h00208463);
    cyc("beq_trap", 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1);
    do_reset("beq_off");
`endif

    // Reset while an LD sits in MEMORIA: nothing may commit.
    fetch_dec("ld_abort", 32'h0000B183);
    cyc("ld_abort_exec", 3'd2, 0, 0, 2'd0, 0, 0, 2'd0, 1, 0, 0);
    do_reset("ld_abort");
    cyc("after_abort_busca", 3'd0, 1, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);
    check("after_abort_dec", 32'(observed()), 32'(pack(3'd1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0)));
    do_reset("after_abort");

    fetch_dec("ill", 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++)
      cyc("ill_trava", 3'd7, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1);
    do_reset("ill");
    cyc("ill_recover_busca", 3'd0, 1, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
